dmem_arbiter: RTL
=================

# dmem_arbiter

Round-robin arbiter that shares one single-port data memory between the two cores of the dual-core CPU. Each core issues word load/store requests through a req/ack handshake; the arbiter serializes them onto the memory port, returns read data, flags out-of-range addresses and counts contention events. It sits between the two MEM pipeline stages and the data memory.

## Interface
- MEM_BYTES, 128: memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- CNT_W, 16: width of the contention counter.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i_1 / req_i_2  in  1  access request from core 1 / core 2; held high until ack.
- we_i_1 / we_i_2  in  1  1 = store, 0 = load; stable while req is high.
- addr_i_1 / addr_i_2  in  32  byte address; bits [1:0] ignored.
- data_i_1 / data_i_2  in  32  store data.
- ack_o_1 / ack_o_2  out  1  one-cycle completion pulse.
- data_o_1 / data_o_2  out  32  load data; valid while ack is high, held afterwards.
- err_o_1 / err_o_2  out  1  high with ack when the address was out of range.
- stall_o_1 / stall_o_2  out  1  req & ~ack; freezes the requesting core's pipeline.
- mem_addr_o  out  32  word-aligned address to memory, with [1:0] = 0.
- mem_data_o  out  32  store data to memory.
- mem_read_o / mem_write_o  out  1  memory strobes; high for exactly one cycle per access.
- mem_data_i  in  32  memory read data; combinational from mem_addr_o while mem_read_o is high.
- conflict_cnt_o  out  CNT_W  saturating count of arbitration decisions where both ports requested.

## Operation
- FSM states are IDLE, ACCESS and RESP. Captured registers are gnt (1 or 2), last (1 or 2), we, addr and wdata.
- In IDLE, arbitration runs at each edge:
  - If only one port requests, that port is granted.
  - If both request, the port != last is granted and conflict_cnt increments.
  - The granted port's we, addr and wdata are captured, last is set to that port, and the FSM goes to ACCESS.
  - With no request, the FSM stays in IDLE.
- In ACCESS:
  - If addr < MEM_BYTES, mem_read_o = ~we and mem_write_o = we, with mem_addr_o = {addr[31:2], 2'b00}. On the edge, a load captures mem_data_i into the granted port's data_o.
  - If addr >= MEM_BYTES, no strobe is raised. The granted port's data_o is set to 0 and an error is recorded.
  - The FSM goes to RESP.
- In RESP:
  - ack_o_gnt is 1, and err_o_gnt = 1 if an error was recorded.
  - A store leaves data_o unchanged.
  - At the edge, only the non-granted port's req is examined. If it is high, that port is granted, captured and counted as a conflict (the granted port's req is still high), and the FSM goes straight to ACCESS. Otherwise the FSM goes to IDLE.
- A requester must drop req or present a new request in the cycle after ack. A req held across RESP is not re-served from RESP.
- conflict_cnt_o saturates at 2^CNT_W-1 and never wraps.
- mem_addr_o and mem_data_o are driven from the captured registers in every state; the strobes alone qualify them.

## Timing
- Reset, asynchronous and immediate:
  - State = IDLE, last = 2 (so port 1 wins the first tie).
  - All ack, err, strobe and stall outputs = 0. data_o_1 = data_o_2 = 0. mem_addr_o = mem_data_o = 0. conflict_cnt_o = 0.
  - Reset during ACCESS drops the strobe in the same cycle, with no write performed after the reset edge. The pending request is discarded, and the core re-requests after reset.
- Latency from req sampled high in IDLE: ACCESS in cycle +1 and ack in cycle +2 (three cycles including the request cycle). Store data is written at the edge ending ACCESS.
- Back-to-back alternating traffic gives one access per 2 cycles. A single port repeating requests gets one access per 3 cycles, because it passes through IDLE.
- The stall outputs are combinational from req and ack.
- Worst-case wait for a requester is one foreign access (round-robin).

## Test plan
- Single load: reset with memory word 2 = 0xFFFFFF9C, then req_i_1 = 1, we_i_1 = 0, addr_i_1 = 8. Required: mem_read_o high in cycle +1 with mem_addr_o = 8, then ack_o_1 and data_o_1 = 0xFFFFFF9C in cycle +2, with stall_o_1 = 1 in cycles 0..1.
- Simultaneous requests after reset: core 1 stores 5 to address 0x40, core 2 loads 0x40. Required: port 1 is served first (write in ACCESS), port 2 is granted directly from RESP, ack_o_2 arrives 2 cycles after ack_o_1 with data_o_2 = 5, and conflict_cnt_o = 2.
- Fairness: both ports hold requests continuously, re-asserting after each ack, for 10 accesses. Required: grants alternate 1,2,1,2…, and no port waits more than one foreign access.
- Out-of-range access: addr_i_2 = 0x80 with MEM_BYTES = 128, issued as a store and then as a load. Required: no mem_write_o or mem_read_o, ack_o_2 with err_o_2 = 1, and data_o_2 = 0 for the load.
- Misaligned address: load with addr_i_1 = 0x0B. Required: mem_addr_o = 0x08 and the same data as an address-8 load.
- Reset mid-access: assert rst_i during ACCESS of a store. Required: mem_write_o = 0 at once, the target word is unchanged, and all outputs show reset values. Separately, force conflict_cnt to 0xFFFE and issue 3 conflicts; the counter must stick at 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between the two cores of the dual-core
// CPU. Each core raises a word load/store request and holds it until a
// one-cycle ack. Requests are served one at a time with round-robin priority.
// Out-of-range addresses complete with an error instead of touching memory.
// Arbitration decisions taken while both ports were requesting are counted.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i_n, we_i_n              request and store/load select from core n
//   addr_i_n, data_i_n           byte address and store data from core n
//   ack_o_n, err_o_n             completion pulse, out-of-range flag
//   data_o_n                     load data, held after the ack
//   stall_o_n                    request pending and not yet acknowledged
//   mem_addr_o, mem_data_o       word address and store data to memory
//   mem_read_o, mem_write_o      one-cycle memory strobes
//   mem_data_i                   combinational read data from memory
//   conflict_cnt_o               saturating count of contended decisions
module dmem_arbiter #(
   parameter int MEM_BYTES = 128,
   parameter int CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i_1,
   input  logic             req_i_2,
   input  logic             we_i_1,
   input  logic             we_i_2,
   input  logic [31:0]      addr_i_1,
   input  logic [31:0]      addr_i_2,
   input  logic [31:0]      data_i_1,
   input  logic [31:0]      data_i_2,
   output logic             ack_o_1,
   output logic             ack_o_2,
   output logic [31:0]      data_o_1,
   output logic [31:0]      data_o_2,
   output logic             err_o_1,
   output logic             err_o_2,
   output logic             stall_o_1,
   output logic             stall_o_2,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_data_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   input  logic [31:0]      mem_data_i,
   output logic [CNT_W-1:0] conflict_cnt_o
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   logic        gnt;
   logic        last;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        pick_valid;
   logic        pick_port;
   logic        pick_conflict;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_ok;
   logic        addr_ok;

   // Port encoding is 0 = core 1, 1 = core 2. In IDLE a tie goes to the port
   // that was not served last. In RESP only the waiting (non-granted) port is
   // considered, and it always counts as contended because the granted core
   // still holds its req during its ack cycle.
   always_comb begin
      pick_valid    = 1'b0;
      pick_port     = 1'b0;
      pick_conflict = 1'b0;
      case (state)
         IDLE: begin
            if (req_i_1 && req_i_2) begin
               pick_valid    = 1'b1;
               pick_port     = ~last;
               pick_conflict = 1'b1;
            end else if (req_i_1) begin
               pick_valid = 1'b1;
               pick_port  = 1'b0;
            end else if (req_i_2) begin
               pick_valid = 1'b1;
               pick_port  = 1'b1;
            end
         end
         RESP: begin
            if (gnt ? req_i_1 : req_i_2) begin
               pick_valid    = 1'b1;
               pick_port     = ~gnt;
               pick_conflict = 1'b1;
            end
         end
         default: begin
         end
      endcase
      sel_we    = pick_port ? we_i_2   : we_i_1;
      sel_addr  = pick_port ? addr_i_2 : addr_i_1;
      sel_wdata = pick_port ? data_i_2 : data_i_1;
      sel_ok    = (sel_addr < MEM_LIMIT);
   end

   assign addr_ok = (addr_q < MEM_LIMIT);

   // Memory address and store data always reflect the captured request; only
   // the strobes say whether the memory should act on them.
   assign mem_addr_o = {addr_q[31:2], 2'b00};
   assign mem_data_o = wdata_q;

   // Stall is held low during reset so a reset core pipeline is never frozen.
   assign stall_o_1 = req_i_1 & ~ack_o_1 & ~rst_i;
   assign stall_o_2 = req_i_2 & ~ack_o_2 & ~rst_i;

   // Main controller. The strobes are decided when the request is captured,
   // so they are flops that the asynchronous reset clears immediately and no
   // write can follow a reset edge. Out-of-range accesses clear the granted
   // port's data_o whether they were loads or stores.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         gnt            <= 1'b0;
         last           <= 1'b1;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         ack_o_1        <= 1'b0;
         ack_o_2        <= 1'b0;
         err_o_1        <= 1'b0;
         err_o_2        <= 1'b0;
         data_o_1       <= '0;
         data_o_2       <= '0;
         mem_read_o     <= 1'b0;
         mem_write_o    <= 1'b0;
         conflict_cnt_o <= '0;
      end else begin
         ack_o_1     <= 1'b0;
         ack_o_2     <= 1'b0;
         err_o_1     <= 1'b0;
         err_o_2     <= 1'b0;
         mem_read_o  <= 1'b0;
         mem_write_o <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (pick_valid) begin
                  state       <= ACCESS;
                  gnt         <= pick_port;
                  last        <= pick_port;
                  we_q        <= sel_we;
                  addr_q      <= sel_addr;
                  wdata_q     <= sel_wdata;
                  mem_read_o  <= sel_ok & ~sel_we;
                  mem_write_o <= sel_ok & sel_we;
                  if (pick_conflict && (conflict_cnt_o != {CNT_W{1'b1}})) begin
                     conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               state   <= RESP;
               ack_o_1 <= ~gnt;
               ack_o_2 <= gnt;
               err_o_1 <= ~gnt & ~addr_ok;
               err_o_2 <= gnt & ~addr_ok;
               if (!addr_ok) begin
                  if (gnt) data_o_2 <= '0;
                  else     data_o_1 <= '0;
               end else if (!we_q) begin
                  if (gnt) data_o_2 <= mem_data_i;
                  else     data_o_1 <= mem_data_i;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
